// File: rtl/layer_in_collect.sv
// rtl/layer_in_collect.sv - assembles LSB-first serial words into one wide vector with a hold/handshake stage.
// Optional sticky overflow flag for words dropped while holding: define COLLECT_OVF_EN.
module layer_in_collect #(
  parameter int no_words   = 30,
  parameter int data_width = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [data_width-1:0]          in,
  input  logic                           in_valid,
  output logic [no_words*data_width-1:0] out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [7:0]                     word_cnt
`ifdef COLLECT_OVF_EN
  ,
  output logic                           ovf
`endif
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam logic [7:0] LAST_SLOT = 8'(no_words - 1);

  state_t                         state_q, state_d;
  logic [7:0]                     cnt_q, cnt_d;
  logic [no_words*data_width-1:0] vec_q, vec_d;
  logic                           wr_en;
  logic [7:0]                     wr_slot;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_slot = cnt_q;
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (cnt_q == LAST_SLOT) begin
            state_d = HOLD;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = COLLECT;
          // Zero-bubble: the word arriving with the handshake opens the next vector.
          if (in_valid) begin
            wr_en   = 1'b1;
            wr_slot = 8'd0;
            if (LAST_SLOT == 8'd0) begin
              state_d = HOLD;
              cnt_d   = 8'd0;
            end else begin
              cnt_d = 8'd1;
            end
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    vec_d = vec_q;
    for (int k = 0; k < no_words; k++) begin
      if (wr_en && (wr_slot == 8'(k))) begin
        vec_d[k*data_width +: data_width] = in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= 8'd0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
    end
  end

  assign out       = vec_q;
  assign out_valid = (state_q == HOLD);
  assign word_cnt  = cnt_q;

`ifdef COLLECT_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == HOLD) && in_valid && !out_ready) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_layer_in_collect.sv
// tb/tb_layer_in_collect.sv - scoreboard bench for layer_in_collect (no_words=4 and no_words=1 instances).
module tb_layer_in_collect;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        din_valid;
  logic [63:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [7:0]  word_cnt;
  logic [15:0] din1;
  logic        din1_valid;
  logic [15:0] dout1;
  logic        dout1_valid;
  logic        dout1_ready;
  logic [7:0]  word_cnt1;
`ifdef COLLECT_OVF_EN
  logic        ovf;
  logic        ovf1;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] q4[$];
  logic [15:0] q1[$];
  logic [63:0] held;

  layer_in_collect #(.no_words(4), .data_width(16)) dut (
    .clk(clk), .rst(rst), .in(din), .in_valid(din_valid),
    .out(dout), .out_valid(dout_valid), .out_ready(dout_ready), .word_cnt(word_cnt)
`ifdef COLLECT_OVF_EN
    , .ovf(ovf)
`endif
  );

  layer_in_collect #(.no_words(1), .data_width(16)) dut1 (
    .clk(clk), .rst(rst), .in(din1), .in_valid(din1_valid),
    .out(dout1), .out_valid(dout1_valid), .out_ready(dout1_ready), .word_cnt(word_cnt1)
`ifdef COLLECT_OVF_EN
    , .ovf(ovf1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Handshakes are resolved on values settled since the previous edge.
  task automatic step();
    if (dout_valid && dout_ready) begin
      if (q4.size() == 0) chk("sb4_underflow", 64'd1, 64'd0);
      else chk("vec4", dout, q4.pop_front());
    end
    if (dout1_valid && dout1_ready) begin
      if (q1.size() == 0) chk("sb1_underflow", 64'd1, 64'd0);
      else chk("vec1", 64'(dout1), 64'(q1.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [15:0] d, input logic r);
    din_valid  = 1'b1;
    din        = d;
    dout_ready = r;
    step();
    din_valid  = 1'b0;
  endtask

  task automatic idle(input logic r);
    din_valid  = 1'b0;
    dout_ready = r;
    step();
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    din1 = '0; din1_valid = 1'b0; dout1_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_cnt", 64'(word_cnt), 64'd0);
    chk("rst_out", dout, 64'd0);
    chk("rst_valid1", 64'(dout1_valid), 64'd0);
`ifdef COLLECT_OVF_EN
    chk("rst_ovf", 64'(ovf), 64'd0);
`endif

    // Consecutive words, ready held high.
    q4.push_back(64'h0004_0003_0002_0001);
    word(16'h0001, 1'b1);
    word(16'h0002, 1'b1);
    word(16'h0003, 1'b1);
    chk("b2b_valid_early", 64'(dout_valid), 64'd0);
    word(16'h0004, 1'b1);
    chk("b2b_valid", 64'(dout_valid), 64'd1);
    chk("b2b_cnt", 64'(word_cnt), 64'd0);
    chk("b2b_out", dout, 64'h0004_0003_0002_0001);
    idle(1'b1);
    chk("b2b_valid_drop", 64'(dout_valid), 64'd0);

    // Gapped words; ready high during COLLECT must be ignored.
    q4.push_back(64'h0004_0003_0002_0001);
    for (int i = 1; i <= 4; i++) begin
      word(16'(i), 1'b1);
      chk("gap_cnt", 64'(word_cnt), (i == 4) ? 64'd0 : 64'(i));
      if (i < 4) begin
        idle(1'b1);
        idle(1'b1);
      end
    end
    chk("gap_valid", 64'(dout_valid), 64'd1);

    // Hold with ready low while words keep arriving: dropped.
    held = dout;
    for (int i = 0; i < 5; i++) begin
      word(16'hDEAD, 1'b0);
      chk("hold_out", dout, held);
      chk("hold_valid", 64'(dout_valid), 64'd1);
      chk("hold_cnt", 64'(word_cnt), 64'd0);
`ifdef COLLECT_OVF_EN
      chk("hold_ovf", 64'(ovf), 64'd1);
`endif
    end
    idle(1'b1);
    chk("hold_release", 64'(dout_valid), 64'd0);

    // Zero-bubble handoff.
    q4.push_back(64'h0040_0030_0020_0010);
    word(16'h0010, 1'b0);
    word(16'h0020, 1'b0);
    word(16'h0030, 1'b0);
    word(16'h0040, 1'b0);
    idle(1'b0);
    chk("zb_hold", 64'(dout_valid), 64'd1);
    q4.push_back(64'h00DD_00CC_00BB_00AA);
    word(16'h00AA, 1'b1);
    chk("zb_valid", 64'(dout_valid), 64'd0);
    chk("zb_cnt", 64'(word_cnt), 64'd1);
    word(16'h00BB, 1'b0);
    word(16'h00CC, 1'b0);
    word(16'h00DD, 1'b0);
    chk("zb_out", dout, 64'h00DD_00CC_00BB_00AA);
    idle(1'b1);

    // Reset mid-vector discards the partial vector.
    word(16'h0055, 1'b0);
    word(16'h0066, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_cnt", 64'(word_cnt), 64'd0);
    chk("mid_rst_out", dout, 64'd0);
`ifdef COLLECT_OVF_EN
    chk("mid_rst_ovf", 64'(ovf), 64'd0);
`endif
    q4.push_back(64'h0044_0033_0022_0011);
    word(16'h0011, 1'b0);
    word(16'h0022, 1'b0);
    word(16'h0033, 1'b0);
    word(16'h0044, 1'b0);
    chk("mid_rst_valid", 64'(dout_valid), 64'd1);
    idle(1'b1);
`ifdef COLLECT_OVF_EN
    chk("mid_rst_ovf_end", 64'(ovf), 64'd0);
`endif

    // Single-word vectors, back-to-back with ready held high.
    dout1_ready = 1'b1;
    din1_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din1 = 16'h000A + 16'(i);
      q1.push_back(din1);
      step();
      chk("nw1_valid", 64'(dout1_valid), 64'd1);
      chk("nw1_out", 64'(dout1), 64'(16'h000A + 16'(i)));
    end
    din1_valid = 1'b0;
    step();
    chk("nw1_drop", 64'(dout1_valid), 64'd0);

    chk("sb4_empty", 64'(q4.size()), 64'd0);
    chk("sb1_empty", 64'(q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/layer_in_collect.md
LAYER_IN_COLLECT -- requirements
Module: layer_in_collect

Interface
REQ-001 SHALL have parameter no_words, default 30: number of data_width words forming one output vector (range 1..255).
REQ-002 SHALL have parameter data_width, default 16: width of one serial word.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in, input, data_width: serial data word from the upstream layer serializer.
REQ-006 SHALL have port in_valid, input, 1: in carries a word this cycle; no backpressure to upstream.
REQ-007 SHALL have port out, output, no_words*data_width: assembled vector; word k occupies bits [k*data_width +: data_width].
REQ-008 SHALL have port out_valid, output, 1: out holds a complete vector.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts the vector when it is high together with out_valid.
REQ-010 SHALL have port word_cnt, output, 8: number of words stored in the vector currently being collected.
REQ-011 SHALL have port ovf, output, 1: sticky overflow flag (present only with COLLECT_OVF_EN).

Function
REQ-012 SHALL implement two states: COLLECT and HOLD.
REQ-013 In COLLECT, each cycle with in_valid=1 SHALL write in to slot word_cnt and increment word_cnt.
- The first word received goes to slot 0 (LSBs), matching the LSB-first order of the upstream shift-right serializer.
REQ-014 When the word written is slot no_words-1, the block SHALL enter HOLD.
- out_valid=1 from the next cycle: latency of one cycle after the last word.
- word_cnt is set to 0.
REQ-015 In HOLD, out and out_valid SHALL stay stable until a cycle with out_ready=1.
REQ-016 On a HOLD cycle with out_ready=1, the block SHALL clear out_valid and return to COLLECT from the next cycle.
REQ-017 If in_valid=1 in the same HOLD cycle that out_ready=1, the block SHALL store that word as slot 0 of the next vector and set word_cnt=1 (zero-bubble).
REQ-018 If in_valid=1 in a HOLD cycle with out_ready=0, the block SHALL drop the word and leave out unchanged.
REQ-019 With no_words=1, every accepted word SHALL produce a vector; REQ-017 then yields back-to-back vectors when out_ready is held high.
REQ-020 out_ready SHALL be ignored in COLLECT.
REQ-021 Slots not yet rewritten in the current vector SHALL retain their previous contents; out is defined only while out_valid=1.
REQ-022 Gaps (in_valid=0) between words SHALL be tolerated with no timeout.

Reset
REQ-023 On rst=1 at a clock edge, the block SHALL set state=COLLECT, word_cnt=0, out_valid=0, out all zeros and ovf=0; this has priority over all other inputs.
REQ-024 On reset mid-vector, the block SHALL discard the partial vector; the first word after reset goes to slot 0.

Configuration
REQ-025 Macro COLLECT_OVF_EN, when defined, SHALL include the ovf port and flag.
- ovf is set in the cycle after any word dropped per REQ-018.
- ovf stays set until rst.
REQ-026 Without COLLECT_OVF_EN, the ovf port and its logic SHALL be absent; dropped words are silent; all other behaviour is identical.

Verification (bench: no_words=4, data_width=16)
REQ-027 SHALL cover: words 0x0001,0x0002,0x0003,0x0004 on consecutive cycles, out_ready=1 -> out_valid high one cycle after 0x0004, out=0x0004_0003_0002_0001, then low.
REQ-028 SHALL cover: same words with 2-cycle gaps between them -> identical out; word_cnt steps 1,2,3 then 0.
REQ-029 SHALL cover: full vector, out_ready=0 for 5 cycles while in_valid=1 with 0xDEAD -> out unchanged, out_valid held; ovf=1 with COLLECT_OVF_EN; no ovf port without it.
REQ-030 SHALL cover: HOLD with out_ready=1 and in_valid=1 carrying 0x00AA in the same cycle -> out_valid drops, word_cnt=1, and the next vector has slot 0 = 0x00AA.
REQ-031 SHALL cover: rst after 2 of 4 words, then 0x0011,0x0022,0x0033,0x0044 -> out=0x0044_0033_0022_0011; ovf=0.
REQ-032 SHALL cover: no_words=1, in_valid=1 for 3 cycles with 0x0A,0x0B,0x0C, out_ready=1 -> three vectors 0x000A,0x000B,0x000C, with out_valid high every cycle from the second.
